// File: rtl/csrng_state_db_wr_arb.sv
// csrng_state_db_wr_arb: round-robin arbiter and sequencer for the CSRNG state database write port.
// Ports: clk_i/rst_ni clock and async active-low reset; enable_i soft clear;
// req_i/rdy_o and the per-requester payload inputs form the requester side;
// state_db_wr_* is the registered database write port, acked through state_db_sts_*;
// sts_ack_o/sts_o/sts_id_o route each ack back to its owner; err_o is a sticky protocol error.
module csrng_state_db_wr_arb #(
  parameter int NReq        = 2,
  parameter int StateId     = 4,
  parameter int KeyLen      = 256,
  parameter int BlkLen      = 128,
  parameter int CtrLen      = 32,
  parameter int Cmd         = 3,
  parameter int CmdStsWidth = 3,
  parameter int AckTimeout  = 15
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      enable_i,
  input  logic [NReq-1:0]           req_i,
  output logic [NReq-1:0]           rdy_o,
  input  logic [NReq*StateId-1:0]   inst_id_i,
  input  logic [NReq-1:0]           fips_i,
  input  logic [NReq*Cmd-1:0]       ccmd_i,
  input  logic [NReq*KeyLen-1:0]    key_i,
  input  logic [NReq*BlkLen-1:0]    v_i,
  input  logic [NReq*CtrLen-1:0]    res_ctr_i,
  input  logic [NReq*CmdStsWidth-1:0] sts_i,
  output logic                      state_db_wr_req_o,
  input  logic                      state_db_wr_req_rdy_i,
  output logic [StateId-1:0]        state_db_wr_inst_id_o,
  output logic                      state_db_wr_fips_o,
  output logic [Cmd-1:0]            state_db_wr_ccmd_o,
  output logic [KeyLen-1:0]         state_db_wr_key_o,
  output logic [BlkLen-1:0]         state_db_wr_v_o,
  output logic [CtrLen-1:0]         state_db_wr_res_ctr_o,
  output logic [CmdStsWidth-1:0]    state_db_wr_sts_o,
  input  logic                      state_db_sts_ack_i,
  input  logic [StateId-1:0]        state_db_sts_id_i,
  input  logic [CmdStsWidth-1:0]    state_db_sts_sts_i,
  output logic [NReq-1:0]           sts_ack_o,
  output logic [CmdStsWidth-1:0]    sts_o,
  output logic [StateId-1:0]        sts_id_o,
  output logic                      err_o
);
  localparam int IdxW = (NReq > 1) ? $clog2(NReq) : 1;
  localparam int CntW = $clog2(AckTimeout + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, ERROR} state_e;
  state_e state_q, state_d;
  logic [IdxW-1:0] rr_ptr, owner, gnt;
  logic [CntW-1:0] cnt;
  logic err_q, any_req, id_ok, ack_ok, timeout, latch;
  assign any_req = |req_i;
  // Scan from the highest rotated offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    gnt = '0;
    for (int i = NReq - 1; i >= 0; i--)
      if (req_i[(int'(rr_ptr) + i) % NReq]) gnt = IdxW'((int'(rr_ptr) + i) % NReq);
  end
  assign rdy_o = (enable_i && state_q == IDLE && !state_db_sts_ack_i && any_req) ? NReq'(1) << gnt : '0;
  assign latch = |rdy_o;
  assign id_ok = state_db_sts_id_i == state_db_wr_inst_id_o;
  assign ack_ok = state_q == WAIT_ACK && state_db_sts_ack_i && id_ok;
  assign timeout = cnt == CntW'(AckTimeout - 1);
  assign state_db_wr_req_o = state_q == ISSUE;
  assign sts_ack_o = ack_ok ? NReq'(1) << owner : '0;
  assign sts_o = ack_ok ? state_db_sts_sts_i : '0;
  assign sts_id_o = ack_ok ? state_db_sts_id_i : '0;
  assign err_o = err_q;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     state_d = state_db_sts_ack_i ? ERROR : any_req ? ISSUE : IDLE;
      ISSUE:    state_d = state_db_sts_ack_i ? ERROR : state_db_wr_req_rdy_i ? WAIT_ACK : ISSUE;
      WAIT_ACK: state_d = state_db_sts_ack_i ? (id_ok ? IDLE : ERROR) : timeout ? ERROR : WAIT_ACK;
      default:  state_d = ERROR;
    endcase
    if (!enable_i) state_d = IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state_q <= IDLE;
    else state_q <= state_d;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr <= '0;
      owner <= '0;
      cnt <= '0;
      err_q <= 1'b0;
      state_db_wr_inst_id_o <= '0;
      state_db_wr_fips_o <= 1'b0;
      state_db_wr_ccmd_o <= '0;
      state_db_wr_key_o <= '0;
      state_db_wr_v_o <= '0;
      state_db_wr_res_ctr_o <= '0;
      state_db_wr_sts_o <= '0;
    end else if (!enable_i) begin
      rr_ptr <= '0;
      owner <= '0;
      cnt <= '0;
      err_q <= 1'b0;
      state_db_wr_inst_id_o <= '0;
      state_db_wr_fips_o <= 1'b0;
      state_db_wr_ccmd_o <= '0;
      state_db_wr_key_o <= '0;
      state_db_wr_v_o <= '0;
      state_db_wr_res_ctr_o <= '0;
      state_db_wr_sts_o <= '0;
    end else begin
      rr_ptr <= ack_ok ? ((owner == IdxW'(NReq - 1)) ? '0 : owner + 1'b1) : rr_ptr;
      owner <= latch ? gnt : owner;
      cnt <= (state_q == ISSUE) ? '0 :
             (state_q == WAIT_ACK && cnt != CntW'(AckTimeout)) ? cnt + 1'b1 : cnt;
      err_q <= err_q || state_d == ERROR;
      if (latch) begin
        state_db_wr_inst_id_o <= inst_id_i[gnt*StateId +: StateId];
        state_db_wr_fips_o <= fips_i[gnt];
        state_db_wr_ccmd_o <= ccmd_i[gnt*Cmd +: Cmd];
        state_db_wr_key_o <= key_i[gnt*KeyLen +: KeyLen];
        state_db_wr_v_o <= v_i[gnt*BlkLen +: BlkLen];
        state_db_wr_res_ctr_o <= res_ctr_i[gnt*CtrLen +: CtrLen];
        state_db_wr_sts_o <= sts_i[gnt*CmdStsWidth +: CmdStsWidth];
      end
    end
  end
endmodule

// File: tb/tb_csrng_state_db_wr_arb.sv
// tb_csrng_state_db_wr_arb: directed bench for the state database write arbiter.
module tb_csrng_state_db_wr_arb;
  logic clk = 1'b0, rst_ni = 1'b0, enable = 1'b1;
  logic [1:0] req = '0, rdy, sts_ack, fips = 2'b01;
  logic [7:0] inst_id = 8'h73;
  logic [5:0] ccmd = 6'o21, sts = 6'o02;
  logic [511:0] key;
  logic [255:0] v;
  logic [63:0] ctr;
  logic wr_req, wr_rdy = 1'b1, wr_fips, ack = 1'b0, err;
  logic [3:0] wr_id, sid = '0, sts_id;
  logic [2:0] wr_ccmd, wr_sts, ssts = '0, sts_o;
  logic [255:0] wr_key;
  logic [127:0] wr_v;
  logic [31:0] wr_ctr;
  int checks = 0, errors = 0;
  localparam logic [255:0] K0 = {8{32'h1234_5678}}, K1 = {8{32'hCAFE_F00D}};
  localparam logic [127:0] V0 = {4{32'h0BAD_BEEF}}, V1 = {4{32'h5555_AAAA}};
  localparam logic [31:0] C0 = 32'h0000_0042, C1 = 32'h0000_0099;
  csrng_state_db_wr_arb dut (
    .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable), .req_i(req), .rdy_o(rdy),
    .inst_id_i(inst_id), .fips_i(fips), .ccmd_i(ccmd), .key_i(key), .v_i(v),
    .res_ctr_i(ctr), .sts_i(sts), .state_db_wr_req_o(wr_req), .state_db_wr_req_rdy_i(wr_rdy),
    .state_db_wr_inst_id_o(wr_id), .state_db_wr_fips_o(wr_fips), .state_db_wr_ccmd_o(wr_ccmd),
    .state_db_wr_key_o(wr_key), .state_db_wr_v_o(wr_v), .state_db_wr_res_ctr_o(wr_ctr),
    .state_db_wr_sts_o(wr_sts), .state_db_sts_ack_i(ack), .state_db_sts_id_i(sid),
    .state_db_sts_sts_i(ssts), .sts_ack_o(sts_ack), .sts_o(sts_o), .sts_id_o(sts_id), .err_o(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  task automatic mid();
    @(negedge clk);
  endtask
  initial begin
    key = {K1, K0};
    v = {V1, V0};
    ctr = {C1, C0};
    mid();
    chk("rst_rdy", rdy, 0); chk("rst_wr_req", wr_req, 0); chk("rst_err", err, 0);
    chk("rst_sts", sts_o, 0); chk("rst_id", wr_id, 0); chk("rst_ack", sts_ack, 0);
    nxt(); rst_ni = 1'b1;
    // single write from requester 0
    req = 2'b01;
    mid(); chk("s_rdy", rdy, 2'b01); chk("s_wr_req_c0", wr_req, 0);
    nxt(); req = 2'b00;
    mid(); chk("s_wr_req", wr_req, 1); chk("s_id", wr_id, 3); chk("s_fips", wr_fips, 1);
    chk("s_ccmd", wr_ccmd, 1); chk("s_key", wr_key, K0); chk("s_v", wr_v, V0);
    chk("s_ctr", wr_ctr, C0); chk("s_sts", wr_sts, 2); chk("s_rdy_c1", rdy, 0);
    nxt(); ack = 1'b1; sid = 4'd3; ssts = 3'd4;
    mid(); chk("s_sts_ack", sts_ack, 2'b01); chk("s_sts_id", sts_id, 3); chk("s_sts_o", sts_o, 4);
    chk("s_wr_req_c2", wr_req, 0);
    nxt(); ack = 1'b0;
    mid(); chk("s_ack_clr", sts_ack, 0); chk("s_sts_clr", sts_o, 0); chk("s_id_clr", sts_id, 0);
    chk("s_err", err, 0);
    // fairness from reset
    rst_ni = 1'b0; nxt(); rst_ni = 1'b1;
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      mid(); chk("f_rdy", rdy, (k % 2) ? 2'b10 : 2'b01);
      nxt();
      mid(); chk("f_wr_req", wr_req, 1); chk("f_rdy_c1", rdy, 0);
      chk("f_id", wr_id, (k % 2) ? 7 : 3);
      nxt(); ack = 1'b1; sid = (k % 2) ? 4'd7 : 4'd3;
      mid(); chk("f_sts_ack", sts_ack, (k % 2) ? 2'b10 : 2'b01);
      nxt(); ack = 1'b0;
    end
    req = 2'b00;
    // backpressure on requester 1
    req = 2'b10; wr_rdy = 1'b0;
    mid(); chk("b_rdy", rdy, 2'b10);
    nxt(); req = 2'b00;
    for (int k = 0; k < 4; k++) begin
      mid(); chk("b_wr_req", wr_req, 1); chk("b_id", wr_id, 7); chk("b_key", wr_key, K1);
      nxt();
    end
    wr_rdy = 1'b1;
    mid(); chk("b_wr_req_rdy", wr_req, 1);
    nxt(); ack = 1'b1; sid = 4'd7;
    mid(); chk("b_wait", wr_req, 0); chk("b_sts_ack", sts_ack, 2'b10);
    nxt(); ack = 1'b0;
    // id mismatch
    inst_id = 8'h72; req = 2'b01;
    mid(); chk("m_rdy", rdy, 2'b01);
    nxt(); req = 2'b00;
    mid(); chk("m_wr_req", wr_req, 1); chk("m_id", wr_id, 2);
    nxt(); ack = 1'b1; sid = 4'd5;
    mid(); chk("m_sts_ack", sts_ack, 0); chk("m_err_pre", err, 0);
    nxt(); ack = 1'b0; req = 2'b01;
    mid(); chk("m_err", err, 1); chk("m_rdy_blk", rdy, 0); chk("m_wr_req_blk", wr_req, 0);
    nxt();
    mid(); chk("m_rdy_blk2", rdy, 0); chk("m_err_hold", err, 1);
    // recover and complete a write so rr_ptr moves to 1
    enable = 1'b0;
    mid(); chk("r_rdy_dis", rdy, 0);
    nxt(); enable = 1'b1;
    mid(); chk("r_err_clr", err, 0); chk("r_id_clr", wr_id, 0); chk("r_rdy", rdy, 2'b01);
    nxt(); req = 2'b00;
    mid(); chk("r_wr_req", wr_req, 1);
    nxt(); ack = 1'b1; sid = 4'd2;
    mid(); chk("r_sts_ack", sts_ack, 2'b01);
    nxt(); ack = 1'b0;
    // ack timeout
    req = 2'b01;
    mid(); chk("t_rdy", rdy, 2'b01);
    nxt(); req = 2'b00;
    nxt();
    repeat (14) nxt();
    mid(); chk("t_err_pre", err, 0);
    nxt();
    mid(); chk("t_err", err, 1); chk("t_sts_ack", sts_ack, 0);
    // recovery clears rr_ptr so requester 0 wins over requester 1
    req = 2'b11; enable = 1'b0;
    mid(); chk("t_rdy_dis", rdy, 0);
    nxt(); enable = 1'b1;
    mid(); chk("t_err_clr", err, 0); chk("t_rdy_rr", rdy, 2'b01);
    nxt(); req = 2'b00;
    mid(); chk("t_wr_req", wr_req, 1); chk("t_id", wr_id, 2);
    nxt(); ack = 1'b1; sid = 4'd2;
    mid(); chk("t_sts_ack2", sts_ack, 2'b01);
    nxt(); ack = 1'b0;
    // stray ack in IDLE
    ack = 1'b1; sid = 4'd0;
    mid(); chk("x_sts_ack", sts_ack, 0);
    nxt(); ack = 1'b0;
    mid(); chk("x_err", err, 1);
    enable = 1'b0; nxt(); enable = 1'b1;
    // async reset mid-write
    req = 2'b01;
    mid(); chk("a_rdy", rdy, 2'b01);
    nxt(); req = 2'b00;
    mid(); chk("a_wr_req", wr_req, 1);
    #1 rst_ni = 1'b0;
    #1;
    chk("a_wr_req_rst", wr_req, 0); chk("a_id_rst", wr_id, 0); chk("a_err_rst", err, 0);
    chk("a_rdy_rst", rdy, 0); chk("a_key_rst", wr_key, 0); chk("a_sts_ack_rst", sts_ack, 0);
    nxt(); rst_ni = 1'b1;
    nxt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/csrng_state_db_wr_arb.md
# csrng_state_db_wr_arb

Write-port arbiter and sequencer for the CSRNG state database. It shares the database's single write port between NReq command-processing requesters using round-robin arbitration. It allows at most one write in flight, and it routes each write's status acknowledgement back to the requester that issued the write. It also checks the acknowledgement protocol: an unexpected ack, a mismatched ack id, or an ack timeout sets a sticky error and locks out further writes.

## Interface
- NReq, 2: number of write requesters (2..8)
- StateId, 4: instance id width
- KeyLen, 256 / BlkLen, 128 / CtrLen, 32 / Cmd, 3: payload field widths
- AckTimeout, 15: maximum cycles spent in WAIT_ACK before an error is raised

- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active low
- enable_i  in  1  module enable; low acts as a synchronous soft clear
- req_i  in  NReq  per-requester write request; must be held with a stable payload until rdy_o
- rdy_o  out  NReq  one-hot pulse; the payload is captured in this cycle
- inst_id_i  in  NReq×StateId  per-requester instance id
- fips_i  in  NReq  per-requester fips flag
- ccmd_i  in  NReq×Cmd  per-requester command
- key_i / v_i / res_ctr_i  in  NReq×KeyLen / NReq×BlkLen / NReq×CtrLen  per-requester state payload
- sts_i  in  NReq×CSRNG_CMD_STS_WIDTH  per-requester command status
- state_db_wr_req_o  out  1  database write request
- state_db_wr_req_rdy_i  in  1  database ready
- state_db_wr_inst_id_o, _fips_o, _ccmd_o, _key_o, _v_o, _res_ctr_o, _sts_o  out  matching widths  registered payload
- state_db_sts_ack_i  in  1  database write acknowledgement
- state_db_sts_id_i  in  StateId  acknowledged instance id
- state_db_sts_sts_i  in  CSRNG_CMD_STS_WIDTH  acknowledged status
- sts_ack_o  out  NReq  one-hot ack to the owning requester
- sts_o  out  CSRNG_CMD_STS_WIDTH  status broadcast, valid with sts_ack_o
- sts_id_o  out  StateId  id broadcast, valid with sts_ack_o
- err_o  out  1  sticky protocol error

## Operation
- FSM states: IDLE, ISSUE, WAIT_ACK, ERROR. Reset state is IDLE.
- IDLE
  - Grant = first asserted req_i found by searching from rr_ptr upward, modulo NReq.
  - If any request is asserted: rdy_o[grant]=1 (combinational), the payload is latched into the output registers, owner<=grant, next state ISSUE.
  - If no request is asserted: stay in IDLE.
- ISSUE
  - state_db_wr_req_o=1.
  - When state_db_wr_req_rdy_i=1: clear the timeout counter, next state WAIT_ACK.
- WAIT_ACK
  - Counter increments every cycle.
  - On state_db_sts_ack_i with state_db_sts_id_i equal to the latched id:
    - sts_ack_o[owner]=1 (combinational).
    - sts_o and sts_id_o pass the database fields through.
    - rr_ptr<=(owner+1) mod NReq.
    - Next state IDLE.
  - On an ack with a different id: err_o<=1, next state ERROR, no sts_ack_o.
  - If the counter reaches AckTimeout with no ack: err_o<=1, next state ERROR.
- ERROR
  - rdy_o, state_db_wr_req_o and sts_ack_o are held at 0.
  - Exit only via enable_i=0 or reset.
- Ack received in IDLE or ISSUE: err_o<=1, next state ERROR.
- enable_i=0, from any state: next state IDLE; rr_ptr, owner, err_o and the payload registers are all cleared; rdy_o=0 combinationally in that cycle.
- When no ack is being forwarded, sts_o and sts_id_o are 0.
- Reset values: every output is 0; sts_o is CMD_STS_SUCCESS (0); rr_ptr is 0.

## Timing
- Minimum write is 3 cycles, with state_db_wr_req_rdy_i=1 and the database acking one cycle after the write:
  - c0: req_i observed, rdy_o pulses.
  - c1: state_db_wr_req_o high.
  - c2: state_db_sts_ack_i arrives, sts_ack_o pulses.
  - c3: IDLE; the next grant can be made in c3.
- rdy_o is never asserted in the same cycle as state_db_wr_req_o.
- At most one write is outstanding at any time.
- Back-to-back throughput is one write per 3 cycles.
- A requester dropping req_i before rdy_o is legal and is not granted.
- Simultaneous requests are resolved purely by rr_ptr; no requester waits longer than NReq grants.
- The timeout counter saturates at AckTimeout.
- err_o is set on the clock edge following the detecting cycle.

## Test plan
- Single request: requester 0 with id=3, database acks at c2 → rdy_o=01 at c0, state_db_wr_req_o=1 at c1 with inst_id_o=3, sts_ack_o=01 at c2 with sts_id_o=3.
- Fairness: req_i=11 held continuously from reset → grant order 0,1,0,1; rdy_o pulses at c0, c3, c6, c9.
- Backpressure: state_db_wr_req_rdy_i=0 for 4 cycles → state_db_wr_req_o held at 1 with a stable payload; WAIT_ACK entered on the first cycle rdy=1.
- Id mismatch: latched id=2, ack arrives with id=5 → err_o=1 on the next cycle, no sts_ack_o, FSM in ERROR; a subsequent req_i gets no rdy_o.
- Timeout, then recovery: no ack for 15 cycles → err_o=1; drop enable_i for 1 cycle → err_o=0, rr_ptr=0, next request granted normally.
- Stray ack in IDLE → err_o=1; then assert rst_ni mid-write → all outputs 0 asynchronously.
